uart_rx_fsm: RTL

UART receive path controller: the receiving end of the team's UART link, decoding frames produced by the UART transmitter (start bit, DATA_WIDTH data bits LSB-first, optional parity bit, one stop bit). It oversamples the serial line, deserialises data, checks parity and stop bit, and presents each good byte as a parallel word with a one-cycle valid strobe. It sits between the RX pad and the system-side consumer.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_sync.sv | 22 ++
 rtl/uart_rx_fsm.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default frame geometry and
// parity-type constants common to the transmitter and receiver.
package uart_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int OVERSAMPLE_DEF = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } uart_state_e;

    // Parity bit the transmitter appends for a given XOR-of-data and parity type.
    function automatic logic parity_bit(input logic data_xor, input logic typ);
        return data_xor ^ (typ == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous RX line; resets to the idle
// (high) level so reset release never looks like a start bit.
module uart_rx_sync (
    input  logic CLK,
    input  logic RST,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receiver: oversampled start/data/parity/stop decoding with registered
// one-cycle strobes. Define UART_RX_MAJORITY_EN for 3-sample majority voting.
module uart_rx_fsm
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int CNT_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] MID      = CNT_W'(OVERSAMPLE / 2);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic rx_s;

    uart_rx_sync u_sync (
        .CLK (CLK),
        .RST (RST),
        .d_i (RX_IN),
        .q_o (rx_s)
    );

    uart_state_e           state_q,     state_d;
    logic [CNT_W-1:0]      edge_cnt_q,  edge_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q,   bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q,     shift_d;
    logic [DATA_WIDTH-1:0] pdata_q,     pdata_d;
    logic                  par_en_q,    par_en_d;
    logic                  par_typ_q,   par_typ_d;
    logic                  par_fault_q, par_fault_d;
    logic                  stp_fault_q, stp_fault_d;
    logic                  dv_q,        dv_d;
    logic                  pe_q,        pe_d;
    logic                  se_q,        se_d;

    logic sample_pt;
    logic bit_val;
    logic cnt_wrap;
    logic stp_now;

`ifdef UART_RX_MAJORITY_EN
    localparam logic [CNT_W-1:0] MID_M1 = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] MID_P1 = CNT_W'(OVERSAMPLE / 2 + 1);

    logic [1:0] hist_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hist_q <= 2'b11;
        end else begin
            if (edge_cnt_q == MID_M1) hist_q[0] <= rx_s;
            if (edge_cnt_q == MID)    hist_q[1] <= rx_s;
        end
    end

    assign sample_pt = (edge_cnt_q == MID_P1);
    assign bit_val   = majority3(hist_q[0], hist_q[1], rx_s);
`else
    assign sample_pt = (edge_cnt_q == MID);
    assign bit_val   = rx_s;
`endif

    assign cnt_wrap = (edge_cnt_q == CNT_LAST);
    // With OVERSAMPLE=4 the majority decision lands on the wrap cycle, so fold it in.
    assign stp_now  = stp_fault_q | (sample_pt & ~bit_val);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            edge_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            pdata_q     <= '0;
            par_en_q    <= 1'b0;
            par_typ_q   <= 1'b0;
            par_fault_q <= 1'b0;
            stp_fault_q <= 1'b0;
            dv_q        <= 1'b0;
            pe_q        <= 1'b0;
            se_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            edge_cnt_q  <= edge_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            pdata_q     <= pdata_d;
            par_en_q    <= par_en_d;
            par_typ_q   <= par_typ_d;
            par_fault_q <= par_fault_d;
            stp_fault_q <= stp_fault_d;
            dv_q        <= dv_d;
            pe_q        <= pe_d;
            se_q        <= se_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        edge_cnt_d  = edge_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        pdata_d     = pdata_q;
        par_en_d    = par_en_q;
        par_typ_d   = par_typ_q;
        par_fault_d = par_fault_q;
        stp_fault_d = stp_fault_q;
        dv_d        = 1'b0;
        pe_d        = 1'b0;
        se_d        = 1'b0;

        if (state_q != IDLE) begin
            edge_cnt_d = cnt_wrap ? '0 : edge_cnt_q + CNT_ONE;
        end

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d     = START;
                    edge_cnt_d  = '0;
                    bit_cnt_d   = '0;
                    par_en_d    = PAR_EN;
                    par_typ_d   = PAR_TYP;
                    par_fault_d = 1'b0;
                    stp_fault_d = 1'b0;
                end
            end
            START: begin
                if (sample_pt && bit_val) begin
                    state_d    = IDLE;
                    edge_cnt_d = '0;
                end else if (cnt_wrap) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (sample_pt) begin
                    shift_d = {bit_val, shift_q[DATA_WIDTH-1:1]};
                end
                if (cnt_wrap) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? PAR : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_ONE;
                    end
                end
            end
            PAR: begin
                if (sample_pt) begin
                    par_fault_d = (bit_val != parity_bit(^shift_q, par_typ_q));
                end
                if (cnt_wrap) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                stp_fault_d = stp_now;
                if (cnt_wrap) begin
                    state_d = IDLE;
                    if (!par_fault_q && !stp_now) begin
                        pdata_d = shift_q;
                        dv_d    = 1'b1;
                    end else begin
                        pe_d = par_fault_q;
                        se_d = stp_now;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                edge_cnt_d = '0;
            end
        endcase
    end

    assign P_DATA     = pdata_q;
    assign Data_Valid = dv_q;
    assign par_err    = pe_q;
    assign stp_err    = se_q;

endmodule
